// File: rtl/rijndael_pkg.sv
// rijndael_pkg: shared widths, FSM encoding and byte-extract helper for the InvSubBytes engine
package rijndael_pkg;
    localparam int STATE_W   = 128;
    localparam int NUM_BYTES = 16;
    typedef enum logic [1:0] {IDLE, PROC, DONE} inv_sb_state_e;
    function automatic logic [7:0] get_byte(input logic [STATE_W-1:0] s, input logic [3:0] idx);
        return s[{~idx, 3'b000} +: 8];
    endfunction
endpackage

// File: rtl/rijndael_inv_sbox.sv
// rijndael_inv_sbox: combinational 256-entry inverse Rijndael S-box lookup
module rijndael_inv_sbox (
    input  logic [7:0] x_i,
    output logic [7:0] y_o
);
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
    assign y_o = INV_SBOX[x_i];
endmodule

// File: rtl/rijndael_inv_sub_bytes.sv
// rijndael_inv_sub_bytes: sequential InvSubBytes, LANES bytes per cycle with valid/ready on both sides
module rijndael_inv_sub_bytes
    import rijndael_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [STATE_W-1:0] state_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [STATE_W-1:0] state_o,
    output logic               busy_o
);
    localparam int STEPS = NUM_BYTES / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("rijndael_inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
    end
    inv_sb_state_e      fsm_q, fsm_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [STATE_W-1:0] data_q, data_d;
    logic [3:0]         lane_idx [LANES];
    logic [7:0]         lane_out [LANES];
    logic               cnt_last;
    assign cnt_last = cnt_q == CW'(STEPS - 1);
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_idx[k] = 4'(LANES * int'(cnt_q) + k);
        rijndael_inv_sbox u_sbox (
            .x_i(get_byte(data_q, lane_idx[k])),
            .y_o(lane_out[k])
        );
    end
    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        case (fsm_q)
            IDLE: begin
                fsm_d  = in_valid_i ? PROC : IDLE;
                cnt_d  = in_valid_i ? '0 : cnt_q;
                data_d = in_valid_i ? state_i : data_q;
            end
            PROC: begin
                for (int i = 0; i < LANES; i++) data_d[{~lane_idx[i], 3'b000} +: 8] = lane_out[i];
                cnt_d = cnt_last ? cnt_q : cnt_q + 1'b1;
                fsm_d = cnt_last ? DONE : PROC;
            end
            DONE:    fsm_d = out_ready_i ? IDLE : DONE;
            default: fsm_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end
    assign in_ready_o  = fsm_q == IDLE;
    assign out_valid_o = fsm_q == DONE;
    assign busy_o      = fsm_q != IDLE;
    assign state_o     = data_q;
endmodule

// File: tb/tb_rijndael_inv_sub_bytes.sv
// tb_rijndael_inv_sub_bytes: directed and randomised checks of InvSubBytes for LANES=4, 1 and 16
module tb_rijndael_inv_sub_bytes;
    localparam logic [127:0] FIPS_IN  = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
    localparam logic [127:0] FIPS_OUT = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [7:0] FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         in_valid_i = 1'b0, in_valid1 = 1'b0, in_valid16 = 1'b0;
    logic         out_ready_i = 1'b0;
    logic [127:0] state_i = '0;
    logic         in_ready_o, out_valid_o, busy_o;
    logic [127:0] state_o;
    logic         in_ready1, out_valid1, busy1, in_ready16, out_valid16, busy16;
    logic [127:0] state1, state16;
    int           errors = 0;
    int           checks = 0;
    always #5 clk_i = ~clk_i;
    rijndael_inv_sub_bytes #(.LANES(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .state_i(state_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .state_o(state_o), .busy_o(busy_o)
    );
    rijndael_inv_sub_bytes #(.LANES(1)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .state_i(state_i), .out_valid_o(out_valid1), .out_ready_i(out_ready_i),
        .state_o(state1), .busy_o(busy1)
    );
    rijndael_inv_sub_bytes #(.LANES(16)) dut16 (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid16), .in_ready_o(in_ready16),
        .state_i(state_i), .out_valid_o(out_valid16), .out_ready_i(out_ready_i),
        .state_o(state16), .busy_o(busy16)
    );
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_valid_o && !out_ready_i |=> out_valid_o && $stable(state_o))
    else begin
        errors++;
        $error("FAIL sva_hold: out_valid_o=%b state_o=%h while stalled", out_valid_o, state_o);
    end
    function automatic logic [127:0] fwd_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = FWD[s[8*i +: 8]];
        return r;
    endfunction
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [127:0] s);
        state_i = s;
        in_valid_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid_o && n < 40) begin
            @(negedge clk_i);
            n++;
        end
    endtask
    task automatic drain();
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
    endtask
    initial begin
        int n;
        logic [127:0] held, p, s;
        repeat (3) @(negedge clk_i);
        check("rst_in_ready", in_ready_o, 1);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_state", state_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        send(128'h63636363_63636363_63636363_63636363);
        check("t1_busy", busy_o, 1);
        check("t1_ready_busy", in_ready_o, 0);
        wait_done(n);
        check("t1_latency", n, 4);
        check("t1_state", state_o, 0);
        drain();
        check("t1_back_idle", in_ready_o, 1);
        check("t1_valid_drop", out_valid_o, 0);
        send(FIPS_IN);
        wait_done(n);
        check("t2_latency", n, 4);
        check("t2_state", state_o, FIPS_OUT);
        held = state_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("t3_valid_hold", out_valid_o, 1);
            check("t3_state_hold", state_o, held);
            check("t3_ready_low", in_ready_o, 0);
        end
        drain();
        check("t3_idle", in_ready_o, 1);
        state_i = FIPS_IN;
        in_valid_i = 1'b1;
        @(negedge clk_i);
        state_i = '0;
        wait_done(n);
        check("t4_latency", n, 4);
        check("t4_first", state_o, FIPS_OUT);
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        check("t4_idle_ready", in_ready_o, 1);
        check("t4_idle_valid", out_valid_o, 0);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        check("t4_captured", busy_o, 1);
        wait_done(n);
        check("t4_latency2", n, 4);
        check("t4_second", state_o, {16{8'h52}});
        drain();
        send(FIPS_IN);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("t5_ready", in_ready_o, 1);
        check("t5_valid", out_valid_o, 0);
        check("t5_state", state_o, 0);
        check("t5_busy", busy_o, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (i == 2) rst_ni = 1'b1;
            check("t5_no_valid", out_valid_o, 0);
        end
        state_i = FIPS_IN;
        in_valid1 = 1'b1;
        @(negedge clk_i);
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        check("l1_latency", n, 16);
        check("l1_state", state1, FIPS_OUT);
        drain();
        check("l1_idle", in_ready1, 1);
        in_valid16 = 1'b1;
        @(negedge clk_i);
        in_valid16 = 1'b0;
        n = 0;
        while (!out_valid16 && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        check("l16_latency", n, 1);
        check("l16_state", state16, FIPS_OUT);
        drain();
        check("l16_idle", in_ready16, 1);
        for (int it = 0; it < 1000; it++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            s = fwd_state(p);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            send(s);
            wait_done(n);
            check("rand_latency", n, 4);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            check("rand_state", state_o, p);
            check("rand_fwd", fwd_state(state_o), s);
            drain();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
